// File: rtl/pipe_pkg.sv
// Shared definitions for the issue controller: func encodings, source-use
// lookup, the 24-bit instruction layout and the issue FSM state encoding.
package pipe_pkg;

   localparam logic [3:0] FN_ADD = 4'd0;
   localparam logic [3:0] FN_SUB = 4'd1;
   localparam logic [3:0] FN_AND = 4'd2;
   localparam logic [3:0] FN_INC = 4'd3;
   localparam logic [3:0] FN_ST  = 4'd4;
   localparam logic [3:0] FN_OR  = 4'd5;
   localparam logic [3:0] FN_XOR = 4'd6;
   localparam logic [3:0] FN_SLT = 4'd7;
   localparam logic [3:0] FN_NOT = 4'd8;
   localparam logic [3:0] FN_NEG = 4'd9;
   localparam logic [3:0] FN_SHR = 4'd10;
   localparam logic [3:0] FN_SHL = 4'd11;
   localparam logic [3:0] FN_MAX = 4'd12;

   typedef struct packed {
      logic [3:0] rs1;
      logic [3:0] rs2;
      logic [3:0] rd;
      logic [3:0] func;
      logic [7:0] addr;
   } instr_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PAUSE,
      ST_STALL,
      ST_ISSUE
   } state_t;

   // Returns {reads_rs1, reads_rs2} for a func code.
   function automatic logic [1:0] src_use(input logic [3:0] func);
      logic [1:0] use_v;
      case (func)
         FN_INC, FN_NOT, FN_SHR, FN_SHL: use_v = 2'b10;
         FN_ST, FN_NEG:                  use_v = 2'b01;
         default:                        use_v = 2'b11;
      endcase
      return use_v;
   endfunction

endpackage

// File: rtl/issue_fifo.sv
// Generic DEPTH-entry synchronous FIFO; registered storage, head visible the cycle after push.
// Push is ignored when full and pop when empty; o_full is the producer's backpressure.
module issue_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 24
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_dat,
   input  logic         i_pop,
   output logic [W-1:0] o_dat,
   output logic         o_full,
   output logic         o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic [W-1:0] r_mem [DEPTH];
   logic         w_push;
   logic         w_pop;

   // Extra pointer MSB separates full from empty when the index bits match.
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_dat   = r_mem[r_rd_ptr[AW-1:0]];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
   end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue controller: FIFO-buffered instructions issued one per cycle with RAW stalls,
// registered issue strobe one cycle after the pop decision; in_ready drops when the FIFO is full.
module pipe_issue_ctrl
   import pipe_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int WB_LAT = 2,
   parameter int CNT_W  = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_rs1,
   input  logic [3:0]       in_rs2,
   input  logic [3:0]       in_rd,
   input  logic [3:0]       in_func,
   input  logic [7:0]       in_addr,
   input  logic             en,
   output logic             iss_valid,
   output logic [3:0]       iss_rs1,
   output logic [3:0]       iss_rs2,
   output logic [3:0]       iss_rd,
   output logic [3:0]       iss_func,
   output logic [7:0]       iss_addr,
   output logic             busy,
   output logic             err_func,
   output logic [CNT_W-1:0] issue_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   instr_t      w_in;
   instr_t      w_head;
   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic [1:0]  w_use;
   logic        w_hazard;
   state_t      w_state;
   logic        w_pop;
   logic        w_issue;
   logic        w_drop;
   logic        w_stall;

   state_t      r_state;
   logic [WB_LAT-1:0] r_sb_v;
   logic [3:0]  r_sb_rd [WB_LAT];

   assign w_in     = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};
   assign in_ready = ~w_full;
   assign w_push   = in_valid & ~w_full;
   assign busy     = ~w_empty | (|r_sb_v);

   issue_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(instr_t))
   ) u_fifo (
      .i_clk   (CLK),
      .i_rst_n (RST_N),
      .i_push  (w_push),
      .i_dat   (w_in),
      .i_pop   (w_pop),
      .o_dat   (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_comb begin
      w_use    = src_use(w_head.func);
      w_hazard = 1'b0;
      for (int k = 0; k < WB_LAT; k++) begin
         if (r_sb_v[k] &&
             ((w_use[1] && (w_head.rs1 == r_sb_rd[k])) ||
              (w_use[0] && (w_head.rs2 == r_sb_rd[k]))))
            w_hazard = 1'b1;
      end
   end

   // Pause outranks the illegal-func drop, which outranks the hazard check.
   always_comb begin
      w_state = ST_IDLE;
      w_pop   = 1'b0;
      w_issue = 1'b0;
      w_drop  = 1'b0;
      w_stall = 1'b0;
      if (!w_empty) begin
         if (!en) begin
            w_state = ST_PAUSE;
         end else if (w_head.func >= FN_MAX) begin
            w_state = ST_ISSUE;
            w_pop   = 1'b1;
            w_drop  = 1'b1;
         end else if (w_hazard) begin
            w_state = ST_STALL;
            w_stall = 1'b1;
         end else begin
            w_state = ST_ISSUE;
            w_pop   = 1'b1;
            w_issue = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= ST_IDLE;
         iss_valid <= 1'b0;
         iss_rs1   <= '0;
         iss_rs2   <= '0;
         iss_rd    <= '0;
         iss_func  <= '0;
         iss_addr  <= '0;
         err_func  <= 1'b0;
         issue_cnt <= '0;
         stall_cnt <= '0;
         r_sb_v    <= '0;
         for (int k = 0; k < WB_LAT; k++) r_sb_rd[k] <= '0;
      end else begin
         r_state   <= w_state;
         iss_valid <= w_issue;
         if (w_issue) begin
            iss_rs1   <= w_head.rs1;
            iss_rs2   <= w_head.rs2;
            iss_rd    <= w_head.rd;
            iss_func  <= w_head.func;
            iss_addr  <= w_head.addr;
            issue_cnt <= issue_cnt + CNT_W'(1);
         end
         if (w_drop) err_func <= 1'b1;
         if (w_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         // sb[k] tracks the issue made k+1 cycles ago; the oldest falls off the end.
         for (int k = WB_LAT - 1; k > 0; k--) begin
            r_sb_v[k]  <= r_sb_v[k-1];
            r_sb_rd[k] <= r_sb_rd[k-1];
         end
         r_sb_v[0]  <= w_issue;
         r_sb_rd[0] <= w_head.rd;
      end
   end

   a_strobe_only_from_issue: assert property (
      @(posedge CLK) disable iff (!RST_N) (r_state != ST_ISSUE) |-> !iss_valid);

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Randomized and directed bench for pipe_issue_ctrl with a register-ready-time
// reference model and a decoupled issue monitor.
module tb_pipe_issue_ctrl;
   import pipe_pkg::*;

   localparam int DEPTH  = 4;
   localparam int WB_LAT = 2;
   localparam int CNT_W  = 16;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [3:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0, in_func = '0;
   logic [7:0] in_addr = '0;
   logic en = 1'b0;
   logic iss_valid;
   logic [3:0] iss_rs1, iss_rs2, iss_rd, iss_func;
   logic [7:0] iss_addr;
   logic busy, err_func;
   logic [CNT_W-1:0] issue_cnt, stall_cnt;

   pipe_issue_ctrl #(.DEPTH(DEPTH), .WB_LAT(WB_LAT), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
      .en(en), .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
      .iss_func(iss_func), .iss_addr(iss_addr), .busy(busy), .err_func(err_func),
      .issue_cnt(issue_cnt), .stall_cnt(stall_cnt));

   initial forever #5 CLK = ~CLK;

   int     n_checks = 0;
   int     n_errors = 0;
   int     cyc = 0;
   instr_t stim[$];
   instr_t m_q[$];
   instr_t exp_q[$];
   int     iss_log[$];
   int     ready_at[16];
   int     m_issue, m_stall, m_last_iss;
   bit     m_err;
   bit     drv_en = 1'b1;
   int     vld_pct = 100;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   function automatic instr_t mk(input int rs1, input int rs2, input int rd, input int fn, input int addr);
      instr_t t;
      t.rs1 = 4'(rs1); t.rs2 = 4'(rs2); t.rd = 4'(rd); t.func = 4'(fn); t.addr = 8'(addr);
      return t;
   endfunction

   function automatic void model_clear();
      m_q.delete(); stim.delete(); exp_q.delete(); iss_log.delete();
      foreach (ready_at[i]) ready_at[i] = 0;
      m_issue = 0; m_stall = 0; m_err = 1'b0; m_last_iss = -1000;
   endfunction

   // Busy while anything is queued or a result is still in its write-back window.
   function automatic bit m_busy();
      return (m_q.size() > 0) || (cyc - m_last_iss <= WB_LAT);
   endfunction

   function automatic bit m_hazard(input instr_t h);
      bit r1, r2;
      r1 = !(h.func inside {4'd4, 4'd9});
      r2 = !(h.func inside {4'd3, 4'd8, 4'd10, 4'd11});
      return (r1 && ready_at[h.rs1] > cyc) || (r2 && ready_at[h.rs2] > cyc);
   endfunction

   // One clock: called at a falling edge, returns at the next falling edge.
   task automatic step();
      bit rdy;
      instr_t h;
      chk("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
      chk("busy", 32'(busy), 32'(m_busy()));
      chk("issue_cnt", 32'(issue_cnt), 32'(m_issue % (1 << CNT_W)));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("err_func", 32'(err_func), 32'(m_err));
      en = drv_en;
      if (stim.size() > 0 && $urandom_range(0, 99) < vld_pct) begin
         in_valid = 1'b1;
         {in_rs1, in_rs2, in_rd, in_func, in_addr} = stim[0];
      end else begin
         in_valid = 1'b0;
      end
      rdy = (m_q.size() < DEPTH);
      if (m_q.size() > 0 && drv_en) begin
         h = m_q[0];
         if (h.func >= 4'd12) begin
            void'(m_q.pop_front());
            m_err = 1'b1;
         end else if (m_hazard(h)) begin
            if (m_stall < (1 << CNT_W) - 1) m_stall++;
         end else begin
            void'(m_q.pop_front());
            exp_q.push_back(h);
            m_issue++;
            ready_at[h.rd] = cyc + WB_LAT + 1;
            m_last_iss = cyc;
         end
      end
      if (in_valid && rdy) m_q.push_back(stim.pop_front());
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
   endtask

   task automatic do_reset(input int n);
      RST_N = 1'b0;
      in_valid = 1'b1;
      model_clear();
      repeat (n) begin
         #1;
         chk("rst_in_ready", 32'(in_ready), 32'd1);
         chk("rst_iss_valid", 32'(iss_valid), 32'd0);
         chk("rst_iss_fields", 32'({iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_cnts", 32'({issue_cnt, stall_cnt}), 32'd0);
         chk("rst_err", 32'(err_func), 32'd0);
         @(posedge CLK);
         cyc++;
         @(negedge CLK);
      end
      RST_N = 1'b1;
      in_valid = 1'b0;
   endtask

   task automatic run_idle(input int max);
      int n = 0;
      while ((stim.size() > 0 || m_q.size() > 0 || m_busy()) && n < max) begin
         step();
         n++;
      end
      chk("drain_timeout", 32'(n < max), 32'd1);
      step();
      step();
   endtask

   task automatic raw_pair(input string nm, input instr_t a, input instr_t b,
                           input int gap, input int stalls);
      do_reset(1);
      stim.push_back(a);
      stim.push_back(b);
      run_idle(50);
      chk({nm, "_n"}, 32'(iss_log.size()), 32'd2);
      if (iss_log.size() == 2) chk({nm, "_gap"}, 32'(iss_log[1] - iss_log[0]), 32'(gap));
      chk({nm, "_stall"}, 32'(stall_cnt), 32'(stalls));
      chk({nm, "_issue"}, 32'(issue_cnt), 32'd2);
   endtask

   // Monitor: every issue strobe must match the oldest expected instruction.
   initial begin
      instr_t e, got;
      forever begin
         @(posedge CLK);
         #1;
         if (RST_N && iss_valid) begin
            n_checks++;
            got = {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr};
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_issue: got %06h expected no issue (cycle %0d)", got, cyc);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  n_errors++;
                  $display("FAIL iss_fields: got %06h expected %06h (cycle %0d)", got, e, cyc);
               end
            end
            iss_log.push_back(cyc);
         end
      end
   end

   initial begin
      instr_t r;
      @(negedge CLK);
      do_reset(3);

      // Independent back-to-back stream.
      stim.push_back(mk(2, 3, 1, 0, 8'h10));
      stim.push_back(mk(5, 6, 4, 1, 8'h11));
      stim.push_back(mk(8, 9, 7, 2, 8'h12));
      run_idle(50);
      chk("ind_issue", 32'(issue_cnt), 32'd3);
      chk("ind_stall", 32'(stall_cnt), 32'd0);
      chk("ind_n", 32'(iss_log.size()), 32'd3);
      if (iss_log.size() == 3) chk("ind_span", 32'(iss_log[2] - iss_log[0]), 32'd2);

      // Read-after-write pairs.
      raw_pair("raw_rs1", mk(2, 3, 1, 0, 8'h20), mk(1, 0, 5, 8, 8'h21), 3, 2);
      raw_pair("raw_rs2", mk(2, 3, 1, 0, 8'h22), mk(1, 1, 5, 9, 8'h23), 3, 2);
      raw_pair("raw_none", mk(2, 3, 1, 0, 8'h24), mk(1, 7, 5, 4, 8'h25), 1, 0);

      // FIFO fill with issue paused, then release.
      do_reset(1);
      drv_en = 1'b0;
      for (int i = 0; i < 5; i++) stim.push_back(mk(1, 2, 8 + i, 0, 8'h30 + i));
      repeat (6) step();
      chk("full_rdy", 32'(in_ready), 32'd0);
      chk("full_no_issue", 32'(iss_log.size()), 32'd0);
      drv_en = 1'b1;
      run_idle(100);
      chk("full_issue", 32'(issue_cnt), 32'd5);
      chk("full_stall", 32'(stall_cnt), 32'd0);
      chk("full_n", 32'(iss_log.size()), 32'd5);

      // Illegal func between two legal instructions.
      do_reset(1);
      stim.push_back(mk(2, 3, 1, 0, 8'h40));
      stim.push_back(mk(4, 5, 6, 13, 8'h41));
      stim.push_back(mk(6, 7, 4, 5, 8'h42));
      run_idle(50);
      chk("ill_err", 32'(err_func), 32'd1);
      chk("ill_issue", 32'(issue_cnt), 32'd2);
      chk("ill_n", 32'(iss_log.size()), 32'd2);
      repeat (3) step();
      chk("ill_sticky", 32'(err_func), 32'd1);

      // Reset while the second instruction is stalled with two queued.
      do_reset(1);
      stim.push_back(mk(2, 3, 1, 0, 8'h50));
      stim.push_back(mk(1, 2, 5, 1, 8'h51));
      stim.push_back(mk(3, 4, 9, 2, 8'h52));
      repeat (3) step();
      chk("mid_stall", 32'(stall_cnt), 32'd1);
      chk("mid_busy", 32'(busy), 32'd1);
      do_reset(2);
      repeat (10) step();
      chk("mid_no_issue", 32'(iss_log.size()), 32'd0);

      // Randomized traffic with pauses, hazards and occasional illegal funcs.
      do_reset(1);
      vld_pct = 80;
      repeat (800) begin
         if (stim.size() < 2 && $urandom_range(0, 99) < 70) begin
            r = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 99) < 10) ? $urandom_range(12, 15) : $urandom_range(0, 11),
                   $urandom_range(0, 255));
            stim.push_back(r);
         end
         drv_en = ($urandom_range(0, 99) < 85);
         step();
      end
      drv_en = 1'b1;
      vld_pct = 100;
      run_idle(200);
      chk("rand_exp_left", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
